m2s_st_packet_buffer: RTL
=========================

# m2s_st_packet_buffer

Packet-aware Avalon-ST buffer that sits directly downstream of the memory-to-stream DMA source port, absorbing its 512-bit beats into an elastic FIFO and presenting them to the AFU stream consumer. It decouples DMA burst timing from consumer back-pressure, polices SOP/EOP framing, and exposes fill level and sticky framing-error flags. Optionally it accumulates per-stream packet and byte statistics.

## Interface
- DATA_WIDTH, 512, beat width in bits; multiple of 8.
- EMPTY_WIDTH, 6, log2(DATA_WIDTH/8).
- DEPTH, 16, FIFO entries; power of two, 4 to 256.
- AF_THRESHOLD, 12, almost_full asserts when fill level is at or above this value.

- clk_clk  in  1  single clock for all logic.
- reset_reset_n  in  1  asynchronous, active-low reset.
- snk_data  in  DATA_WIDTH  beat from the DMA m2s_st_source.
- snk_valid  in  1  beat valid.
- snk_ready  out  1  buffer accepts a beat this cycle (ready latency 0).
- snk_startofpacket / snk_endofpacket  in  1 each  framing.
- snk_empty  in  EMPTY_WIDTH  unused bytes on the EOP beat.
- src_data, src_valid, src_startofpacket, src_endofpacket, src_empty  out  as sink  beat to the consumer.
- src_ready  in  1  consumer accepts (ready latency 0).
- fill_level  out  log2(DEPTH)+1  entries held.
- almost_full  out  1  fill_level >= AF_THRESHOLD.
- err_missing_sop  out  1  sticky: beat arrived outside a packet without SOP.
- err_unexpected_sop  out  1  sticky: SOP arrived inside an open packet.
- err_clear  in  1  single-cycle pulse clears both sticky errors.
- stat_pkt_count  out  32  packets delivered at src (see Configuration).
- stat_byte_count  out  48  bytes delivered at src (see Configuration).

## Operation
- Write on snk_valid && snk_ready; read on src_valid && src_ready. snk_ready = (fill_level < DEPTH), derived from registered count only; a read in the same cycle does not raise ready when full.
- Stored word = {data, sop, eop, empty}; empty is forced to 0 on non-EOP beats.
- Framing FSM on the sink side, states IDLE and IN_PKT:
  - IDLE + beat with SOP and EOP: stored, stay IDLE.
  - IDLE + beat with SOP, no EOP: stored, go IN_PKT.
  - IDLE + beat without SOP: beat is accepted (ready honoured) but dropped, err_missing_sop set.
  - IN_PKT + beat with SOP: stored as a new packet start, err_unexpected_sop set, stays IN_PKT unless EOP.
  - IN_PKT + beat with EOP: stored, go IDLE.
- Sticky errors: set has priority over err_clear in the same cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; fill_level updated +1 on write-only, -1 on read-only, unchanged on simultaneous write and read.

## Timing
- Reset values: snk_ready 0 while reset asserted, 1 the first cycle after deassertion; src_valid 0; src_* data fields 0; fill_level 0; almost_full 0; both errors 0; stats 0; FSM IDLE.
- Write-to-read latency: beat written in cycle N is visible on src in cycle N+1 (no fall-through when empty).
- src_valid = (fill_level != 0); src outputs hold stable while src_valid && !src_ready.
- Full: DEPTH beats held, snk_ready 0 until a read has reduced fill_level (one cycle later).
- Empty with simultaneous write: fill_level becomes 1, src_valid rises next cycle.
- Reset mid-packet: FIFO contents discarded, FSM to IDLE; next beat must carry SOP.
- Sustained throughput: one beat per cycle when both sides are continuously ready and fill_level is between 1 and DEPTH-1.

## Configuration
- M2S_PKT_STATS_EN defined: on every src transfer, stat_byte_count += (EOP ? DATA_WIDTH/8 - src_empty : DATA_WIDTH/8); stat_pkt_count += 1 on EOP transfers; both wrap modulo 2^width; cleared only by reset.
- Not defined: counters not instantiated; stat_pkt_count and stat_byte_count tied to 0.

## Test plan
- Single 3-beat packet (SOP, mid, EOP empty=10), src_ready held 1 -> three beats on src starting one cycle after the first write, EOP empty=10, fill_level back to 0; with stats: pkt_count 1, byte_count 182.
- src_ready held 0, 20 beats offered with DEPTH=16 -> snk_ready drops after 16 accepts, almost_full at fill_level 12; release src_ready -> all 16 drained in order, then remaining 4 accepted.
- Beat without SOP in IDLE -> not present on src, err_missing_sop 1; err_clear pulse -> 0.
- SOP inside open packet -> beat forwarded with SOP, err_unexpected_sop 1; simultaneous new error and err_clear -> flag stays 1.
- Full FIFO with simultaneous read and write attempt -> write rejected (snk_ready 0), fill_level 15 next cycle, snk_ready 1.
- reset_reset_n asserted mid-packet with 5 entries held -> src_valid 0 and fill_level 0 immediately; post-reset non-SOP beat flags err_missing_sop.

Source files
------------

// File: rtl/m2s_st_packet_buffer.sv
`default_nettype none
// ============================================================================
// Module      : m2s_st_packet_buffer
// Description : Packet-aware Avalon-ST elastic buffer placed downstream of the
//               memory-to-stream DMA source port. Beats are absorbed into a
//               DEPTH-entry FIFO and presented to the AFU stream consumer.
//               SOP/EOP framing is policed on the sink side and violations
//               are reported through sticky error flags.
//
// Optional    : define M2S_PKT_STATS_EN to build the per-stream packet and
//               byte counters. Without it both statistics outputs are tied
//               to zero.
//
// Ports       : clk_clk            - single clock
//               reset_reset_n      - asynchronous active-low reset
//               snk_*              - Avalon-ST sink (ready latency 0)
//               src_*              - Avalon-ST source (ready latency 0)
//               fill_level         - entries currently held
//               almost_full        - fill_level >= AF_THRESHOLD
//               err_missing_sop    - sticky, beat outside packet w/o SOP
//               err_unexpected_sop - sticky, SOP inside an open packet
//               err_clear          - pulse, clears both sticky errors
//               stat_pkt_count     - EOP transfers seen at src
//               stat_byte_count    - bytes transferred at src
//
// Revision    : 1.0 - initial release
// ============================================================================
module m2s_st_packet_buffer #(
    parameter int DATA_WIDTH   = 512,
    parameter int EMPTY_WIDTH  = 6,
    parameter int DEPTH        = 16,
    parameter int AF_THRESHOLD = 12
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,

    input  logic [DATA_WIDTH-1:0]         snk_data,
    input  logic                          snk_valid,
    output logic                          snk_ready,
    input  logic                          snk_startofpacket,
    input  logic                          snk_endofpacket,
    input  logic [EMPTY_WIDTH-1:0]        snk_empty,

    output logic [DATA_WIDTH-1:0]         src_data,
    output logic                          src_valid,
    input  logic                          src_ready,
    output logic                          src_startofpacket,
    output logic                          src_endofpacket,
    output logic [EMPTY_WIDTH-1:0]        src_empty,

    output logic [$clog2(DEPTH):0]        fill_level,
    output logic                          almost_full,
    output logic                          err_missing_sop,
    output logic                          err_unexpected_sop,
    input  logic                          err_clear,

    output logic [31:0]                   stat_pkt_count,
    output logic [47:0]                   stat_byte_count
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_word_w = DATA_WIDTH + 2 + EMPTY_WIDTH;

    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af    = c_cnt_w'(AF_THRESHOLD);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic                   r_ready_en;
    logic                   r_err_missing_sop;
    logic                   r_err_unexpected_sop;
    logic [c_word_w-1:0]    r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                   w_accept;
    logic                   w_drop;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_set_missing;
    logic                   w_set_unexpected;
    logic [EMPTY_WIDTH-1:0] w_wr_empty;
    logic [c_word_w-1:0]    w_wr_word;
    logic [c_word_w-1:0]    w_rd_word;

    // r_ready_en holds ready low while in reset and for the edge that
    // releases it, so the sink never sees ready during reset even though
    // the FIFO is empty.
    assign snk_ready = r_ready_en && (r_count < c_depth);
    assign src_valid = (r_count != '0);

    assign w_accept = snk_valid && snk_ready;
    assign w_rd     = src_valid && src_ready;

    // A headless beat in IDLE is consumed from the sink but never stored.
    assign w_drop           = (r_state == ST_IDLE) && !snk_startofpacket;
    assign w_wr             = w_accept && !w_drop;
    assign w_set_missing    = w_accept && w_drop;
    assign w_set_unexpected = w_accept && (r_state == ST_IN_PKT) && snk_startofpacket;

    // Keep the stored empty field clean on non-EOP beats so downstream
    // byte accounting only ever sees empty on the final beat.
    assign w_wr_empty = snk_endofpacket ? snk_empty : '0;
    assign w_wr_word  = {snk_data, snk_startofpacket, snk_endofpacket, w_wr_empty};

    // ------------------------------------------------------------------
    // Storage (no reset: contents are qualified by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    assign w_rd_word = r_mem[r_rd_ptr];

    // Outputs are gated by src_valid so stale or uninitialised storage is
    // never visible and all src fields read zero when empty.
    assign src_data          = src_valid ? w_rd_word[c_word_w-1 -: DATA_WIDTH] : '0;
    assign src_startofpacket = src_valid ? w_rd_word[EMPTY_WIDTH+1]             : 1'b0;
    assign src_endofpacket   = src_valid ? w_rd_word[EMPTY_WIDTH]               : 1'b0;
    assign src_empty         = src_valid ? w_rd_word[EMPTY_WIDTH-1:0]           : '0;

    // ------------------------------------------------------------------
    // Pointers and fill level
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign fill_level  = r_count;
    assign almost_full = (r_count >= c_af);

    // ------------------------------------------------------------------
    // Sink-side framing FSM with sticky error flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state              <= ST_IDLE;
            r_err_missing_sop    <= 1'b0;
            r_err_unexpected_sop <= 1'b0;
        end else begin
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (snk_startofpacket && !snk_endofpacket) begin
                            r_state <= ST_IN_PKT;
                        end
                    end
                    ST_IN_PKT: begin
                        if (snk_endofpacket) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            // A new violation wins over a clear arriving in the same cycle.
            if (w_set_missing) begin
                r_err_missing_sop <= 1'b1;
            end else if (err_clear) begin
                r_err_missing_sop <= 1'b0;
            end

            if (w_set_unexpected) begin
                r_err_unexpected_sop <= 1'b1;
            end else if (err_clear) begin
                r_err_unexpected_sop <= 1'b0;
            end
        end
    end

    assign err_missing_sop    = r_err_missing_sop;
    assign err_unexpected_sop = r_err_unexpected_sop;

    // ------------------------------------------------------------------
    // Optional delivery statistics
    // ------------------------------------------------------------------
`ifdef M2S_PKT_STATS_EN
    localparam logic [47:0] c_beat_bytes = 48'(DATA_WIDTH / 8);

    logic [31:0] r_pkt_count;
    logic [47:0] r_byte_count;
    logic [47:0] w_xfer_bytes;

    assign w_xfer_bytes = src_endofpacket ? (c_beat_bytes - 48'(src_empty)) : c_beat_bytes;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pkt_count  <= '0;
            r_byte_count <= '0;
        end else if (w_rd) begin
            r_byte_count <= r_byte_count + w_xfer_bytes;
            if (src_endofpacket) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign stat_pkt_count  = r_pkt_count;
    assign stat_byte_count = r_byte_count;
`else
    assign stat_pkt_count  = '0;
    assign stat_byte_count = '0;
`endif

endmodule
`default_nettype wire
